// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - command/response and shifter-side signals of shift_sequencer
interface shift_sequencer_if #(
    parameter int AMT_W = 3
);
    logic             start;
    logic [1:0]       cmd_op;
    logic [AMT_W-1:0] cmd_amt;
    logic [7:0]       cmd_data;
    logic             busy;
    logic             done;
    logic [7:0]       result;
    logic             cmd_err;
    logic [2:0]       sh_op;
    logic [1:0]       sh_shamt;
    logic [7:0]       sh_d_in;
    logic [7:0]       sh_d_out;

    modport master (
        output start, cmd_op, cmd_amt, cmd_data, sh_d_out,
        input  busy, done, result, cmd_err, sh_op, sh_shamt, sh_d_in
    );

    modport slave (
        input  start, cmd_op, cmd_amt, cmd_data, sh_d_out,
        output busy, done, result, cmd_err, sh_op, sh_shamt, sh_d_in
    );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - splits one shift command into <=3-bit steps for shifter8
module shift_sequencer #(
    parameter int AMT_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    shift_sequencer_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_LSL  = 3'b010;
    localparam logic [2:0] SH_LSR  = 3'b011;
    localparam logic [2:0] SH_ASR  = 3'b100;

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [AMT_W-1:0] r_rem;
    logic [2:0]       r_sh_op;
    logic [1:0]       r_sh_shamt;
    logic [7:0]       r_sh_d_in;
    logic [7:0]       r_result;
    logic             r_done;
    logic             r_cmd_err;

    logic             w_accept;
    logic             w_illegal;
    logic [AMT_W-1:0] w_rem_dec;
    logic [1:0]       w_state_nxt;
    logic [AMT_W-1:0] w_rem_nxt;
    logic [1:0]       w_op_nxt;
    logic [1:0]       w_step;
    logic [2:0]       w_shift_code;
    logic [2:0]       w_sh_op_nxt;
    logic [1:0]       w_sh_shamt_nxt;

    assign w_accept  = (r_state == S_IDLE) && bus.start && (bus.cmd_op != 2'b11);
    assign w_illegal = (r_state == S_IDLE) && bus.start && (bus.cmd_op == 2'b11);
    assign w_rem_dec = r_rem - AMT_W'(r_sh_shamt);

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_LOAD;
                    w_rem_nxt   = bus.cmd_amt;
                    w_op_nxt    = bus.cmd_op;
                end
            end
            S_LOAD:  w_state_nxt = (r_rem != '0) ? S_SHIFT : S_DONE;
            S_SHIFT: begin
                w_rem_nxt = w_rem_dec;
                if (w_rem_dec == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shifter controls are registered, so they are derived from the state being entered.
    always_comb begin
        w_step = (w_rem_nxt > AMT_W'(3)) ? 2'd3 : w_rem_nxt[1:0];
        case (w_op_nxt)
            2'b00:   w_shift_code = SH_LSL;
            2'b01:   w_shift_code = SH_LSR;
            2'b10:   w_shift_code = SH_ASR;
            default: w_shift_code = SH_NOP;
        endcase
        case (w_state_nxt)
            S_LOAD:  w_sh_op_nxt = SH_LOAD;
            S_SHIFT: w_sh_op_nxt = w_shift_code;
            default: w_sh_op_nxt = SH_NOP;
        endcase
        w_sh_shamt_nxt = (w_state_nxt == S_SHIFT) ? w_step : 2'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op       <= 2'b00;
            r_rem      <= '0;
            r_sh_op    <= SH_NOP;
            r_sh_shamt <= 2'd0;
            r_sh_d_in  <= 8'h00;
            r_result   <= 8'h00;
            r_done     <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_rem      <= w_rem_nxt;
            r_sh_op    <= w_sh_op_nxt;
            r_sh_shamt <= w_sh_shamt_nxt;
            r_done     <= (r_state == S_DONE);
            r_cmd_err  <= w_illegal;
            if (w_accept) begin
                r_sh_d_in <= bus.cmd_data;
            end
            if (r_state == S_DONE) begin
                r_result <= bus.sh_d_out;
            end
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.cmd_err  = r_cmd_err;
    assign bus.sh_op    = r_sh_op;
    assign bus.sh_shamt = r_sh_shamt;
    assign bus.sh_d_in  = r_sh_d_in;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized self-checking bench for shift_sequencer with a shifter8 model
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_sequencer_if #(.AMT_W(3)) bus ();
    shift_sequencer #(.AMT_W(3)) dut (.clk(clk), .reset_n(rst_n), .bus(bus));

    logic [7:0] sh_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q <= 8'h00;
        else begin
            case (bus.sh_op)
                3'd1:    sh_q <= bus.sh_d_in;
                3'd2:    sh_q <= sh_q << bus.sh_shamt;
                3'd3:    sh_q <= sh_q >> bus.sh_shamt;
                3'd4:    sh_q <= $signed(sh_q) >>> bus.sh_shamt;
                default: sh_q <= sh_q;
            endcase
        end
    end
    assign bus.sh_d_out = sh_q;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] last_result = 8'h00;
    logic [1:0] r_op;
    logic [2:0] r_amt;
    logic [7:0] r_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_result(input logic [1:0] op, input int amt, input logic [7:0] d);
        logic signed [7:0] sd;
        sd = d;
        case (op)
            2'b00:   return d << amt;
            2'b01:   return d >> amt;
            default: return sd >>> amt;
        endcase
    endfunction

    // Called at a negedge; cycle 0 is the cycle in which start is presented.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] amt, input logic [7:0] data, input bit poke);
        int steps[$];
        int got[$];
        int rem;
        int k;
        bit seen_done;
        int busy_cycles;
        logic [2:0] exp_code;
        rem = int'(amt);
        while (rem > 0) begin
            steps.push_back((rem > 3) ? 3 : rem);
            rem -= (rem > 3) ? 3 : rem;
        end
        k = steps.size();
        exp_code = (op == 2'b00) ? 3'd2 : (op == 2'b01) ? 3'd3 : 3'd4;
        seen_done = 1'b0;
        busy_cycles = 0;
        bus.start = 1'b1; bus.cmd_op = op; bus.cmd_amt = amt; bus.cmd_data = data;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 1; n <= 20 && !seen_done; n++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            if (bus.sh_op == 3'd1) chk("load_d_in", 32'(bus.sh_d_in), 32'(data));
            if (bus.sh_op >= 3'd2) begin
                got.push_back(int'(bus.sh_shamt));
                chk("shift_op_code", 32'(bus.sh_op), 32'(exp_code));
            end
            if (bus.done) begin
                seen_done = 1'b1;
                chk("done_cycle", n, k + 3);
                chk("result", 32'(bus.result), 32'(ref_result(op, int'(amt), data)));
                chk("busy_at_done", 32'(bus.busy), 0);
            end
            if (poke && n <= 2) begin
                bus.start = 1'b1;
                bus.cmd_op = 2'($urandom_range(0, 2));
                bus.cmd_amt = 3'($urandom);
                bus.cmd_data = 8'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("done_seen", 32'(seen_done), 1);
        chk("busy_cycles", busy_cycles, k + 2);
        chk("step_count", got.size(), k);
        for (int i = 0; i < got.size() && i < k; i++) chk("shamt_step", got[i], steps[i]);
        last_result = ref_result(op, int'(amt), data);
    endtask

    task automatic illegal_cmd();
        bus.start = 1'b1; bus.cmd_op = 2'b11; bus.cmd_amt = 3'($urandom); bus.cmd_data = 8'($urandom);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("cmd_err_pulse", 32'(bus.cmd_err), 1);
        chk("illegal_busy", 32'(bus.busy), 0);
        chk("illegal_result", 32'(bus.result), 32'(last_result));
        @(negedge clk);
        chk("cmd_err_clear", 32'(bus.cmd_err), 0);
        chk("illegal_busy2", 32'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.cmd_op = 2'b00; bus.cmd_amt = 3'd0; bus.cmd_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_cmd_err", 32'(bus.cmd_err), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_sh_op", 32'(bus.sh_op), 0);
        chk("rst_sh_shamt", 32'(bus.sh_shamt), 0);
        chk("rst_sh_d_in", 32'(bus.sh_d_in), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(2'b00, 3'd5, 8'h01, 1'b0);
        run_cmd(2'b10, 3'd7, 8'h80, 1'b0);
        run_cmd(2'b01, 3'd0, 8'hA5, 1'b0);
        illegal_cmd();
        run_cmd(2'b00, 3'd4, 8'h3C, 1'b1);
        @(negedge clk);
        chk("poke_ignored_busy", 32'(bus.busy), 0);
        chk("poke_result_kept", 32'(bus.result), 32'(last_result));

        // Reset while an LSL by 7 is in its SHIFT phase.
        bus.start = 1'b1; bus.cmd_op = 2'b00; bus.cmd_amt = 3'd7; bus.cmd_data = 8'hFF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_shift", 32'(bus.sh_op), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(bus.busy), 0);
        chk("async_result", 32'(bus.result), 0);
        chk("async_sh_op", 32'(bus.sh_op), 0);
        chk("async_sh_shamt", 32'(bus.sh_shamt), 0);
        chk("async_done", 32'(bus.done), 0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_no_done", 32'(bus.done), 0);
        end
        rst_n = 1'b1;
        last_result = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_no_done", 32'(bus.done), 0);
        end
        run_cmd(2'b00, 3'd3, 8'h11, 1'b0);

        repeat (40) begin
            if ($urandom_range(0, 5) == 0) begin
                illegal_cmd();
            end else begin
                r_op = 2'($urandom_range(0, 2));
                r_amt = 3'($urandom);
                r_data = 8'($urandom);
                run_cmd(r_op, r_amt, r_data, $urandom_range(0, 3) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
